// File: rtl/meal_pkg.sv
// Shared types and defaults for the meal arbiter: FSM state encodings and
// default kid count / cook duration.
package meal_pkg;

    typedef enum logic [1:0] {
        SLEEP = 2'd0,
        COOK  = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam int DEF_N_KIDS      = 3;
    localparam int DEF_COOK_CYCLES = 4;

endpackage

// File: rtl/meal_arbiter_if.sv
// Kid-facing bus of the meal arbiter: request/acknowledge in, grant/food/status out.
interface meal_arbiter_if
    import meal_pkg::*;
#(
    parameter int N_KIDS = DEF_N_KIDS
) ();

    logic [N_KIDS-1:0] wakeup;
    logic [N_KIDS-1:0] eaten;
    logic [N_KIDS-1:0] grant;
    logic [N_KIDS-1:0] food;
    logic              busy;
    logic [7:0]        served_cnt;

    modport master (
        output wakeup,
        output eaten,
        input  grant,
        input  food,
        input  busy,
        input  served_cnt
    );

    modport slave (
        input  wakeup,
        input  eaten,
        output grant,
        output food,
        output busy,
        output served_cnt
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin search: first set request bit at or above ptr, wrapping past the top.
module rr_picker
    import meal_pkg::*;
#(
    parameter int N_KIDS = DEF_N_KIDS,
    parameter int IDX_W  = $clog2(N_KIDS)
) (
    input  logic [N_KIDS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N_KIDS; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_KIDS) begin
                pos = pos - N_KIDS;
            end
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/meal_arbiter.sv
// Moore FSM that picks one requesting kid round-robin, cooks for a fixed
// number of cycles, then holds food until that kid acknowledges.
module meal_arbiter
    import meal_pkg::*;
#(
    parameter int N_KIDS      = DEF_N_KIDS,
    parameter int COOK_CYCLES = DEF_COOK_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    meal_arbiter_if.slave  bus
);

    localparam int         IDX_W    = $clog2(N_KIDS);
    localparam logic [7:0] CNT_LAST = 8'(COOK_CYCLES - 1);

    state_t            state;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  ptr;
    logic [7:0]        cnt;
    logic [7:0]        served_cnt;
    logic [N_KIDS-1:0] grant;
    logic [N_KIDS-1:0] food;
    logic              busy;

    logic              found;
    logic [IDX_W-1:0]  pick;

    function automatic logic [N_KIDS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_KIDS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(N_KIDS - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_picker #(
        .N_KIDS (N_KIDS),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (bus.wakeup),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Outputs are loaded together with the state so they never see wakeup/eaten combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SLEEP;
            winner     <= '0;
            ptr        <= '0;
            cnt        <= '0;
            served_cnt <= '0;
            grant      <= '0;
            food       <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                SLEEP: begin
                    if (found) begin
                        winner <= pick;
                        cnt    <= '0;
                        state  <= COOK;
                        grant  <= onehot(pick);
                        busy   <= 1'b1;
                    end
                end
                COOK: begin
                    if (!bus.wakeup[winner]) begin
                        state <= SLEEP;
                        ptr   <= next_idx(winner);
                        grant <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            state <= SERVE;
                            food  <= onehot(winner);
                        end
                    end
                end
                SERVE: begin
                    if (bus.eaten[winner]) begin
                        state      <= SLEEP;
                        ptr        <= next_idx(winner);
                        served_cnt <= served_cnt + 8'd1;
                        grant      <= '0;
                        food       <= '0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= SLEEP;
                    grant <= '0;
                    food  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = grant;
    assign bus.food       = food;
    assign bus.busy       = busy;
    assign bus.served_cnt = served_cnt;

endmodule

// File: tb/tb_meal_arbiter.sv
// Directed bench for meal_arbiter (N_KIDS=3, COOK_CYCLES=4): one vector table
// for the basic meal/abort timeline plus hand-written multi-cycle sequences.
module tb_meal_arbiter;

    localparam int N = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    meal_arbiter_if #(.N_KIDS(N)) bus ();

    meal_arbiter #(
        .N_KIDS      (N),
        .COOK_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] wakeup;
        logic [2:0] eaten;
        logic [2:0] exp_grant;
        logic [2:0] exp_food;
        logic       exp_busy;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.wakeup = '0;
        bus.eaten  = '0;
        tick();
        reset = 1'b0;
    endtask

    // Advance until food equals want, bounded by limit cycles.
    task automatic wait_food(input string name, input logic [2:0] want, input int limit);
        int n;
        n = 0;
        while (bus.food !== want && n < limit) begin
            tick();
            n++;
        end
        chk(name, {5'd0, bus.food}, {5'd0, want});
    endtask

    initial begin
        logic [2:0] rr_exp[4];
        int         n;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.wakeup = '0;
        bus.eaten  = '0;
        tick();

        // Single meal, then an abort one cycle into the next cook.
        vecs[0] = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 8'd0};
        vecs[1] = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b1, 8'd0};
        vecs[2] = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b1, 8'd0};
        vecs[3] = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b1, 8'd0};
        vecs[4] = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b1, 8'd0};
        vecs[5] = '{3'b001, 3'b000, 3'b001, 3'b001, 1'b1, 8'd0};
        vecs[6] = '{3'b001, 3'b001, 3'b001, 3'b001, 1'b1, 8'd0};
        vecs[7] = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 8'd1};
        vecs[8] = '{3'b000, 3'b000, 3'b001, 3'b000, 1'b1, 8'd1};
        vecs[9] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 8'd1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_grant", i), {5'd0, bus.grant}, {5'd0, vecs[i].exp_grant});
            chk($sformatf("tbl%0d_food", i),  {5'd0, bus.food},  {5'd0, vecs[i].exp_food});
            chk($sformatf("tbl%0d_busy", i),  {7'd0, bus.busy},  {7'd0, vecs[i].exp_busy});
            chk($sformatf("tbl%0d_cnt", i),   bus.served_cnt,    vecs[i].exp_cnt);
            bus.wakeup = vecs[i].wakeup;
            bus.eaten  = vecs[i].eaten;
            tick();
        end

        // Abort: request withdrawn in cycle 3.
        do_reset();
        bus.wakeup = 3'b001;
        tick();
        chk("abort_grant_c1", {5'd0, bus.grant}, 8'h01);
        tick();
        tick();
        bus.wakeup = 3'b000;
        chk("abort_food_c3", {5'd0, bus.food}, 8'h00);
        tick();
        chk("abort_grant_c4", {5'd0, bus.grant}, 8'h00);
        chk("abort_busy_c4", {7'd0, bus.busy}, 8'h00);
        tick();
        tick();
        chk("abort_food_c6", {5'd0, bus.food}, 8'h00);
        chk("abort_cnt", bus.served_cnt, 8'd0);

        // Round robin with all kids requesting.
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        do_reset();
        bus.wakeup = 3'b111;
        for (int m = 0; m < 4; m++) begin
            n = 0;
            while (bus.grant == 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d_grant", m), {5'd0, bus.grant}, {5'd0, rr_exp[m]});
            n = 0;
            while (bus.food == 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d_cook_len", m), 8'(n), 8'd4);
            chk($sformatf("rr%0d_food", m), {5'd0, bus.food}, {5'd0, rr_exp[m]});
            tick();
            chk($sformatf("rr%0d_food_hold", m), {5'd0, bus.food}, {5'd0, rr_exp[m]});
            bus.eaten = rr_exp[m];
            tick();
            bus.eaten = 3'b000;
            chk($sformatf("rr%0d_sleep_gap", m), {7'd0, bus.busy}, 8'h00);
        end
        chk("rr_served", bus.served_cnt, 8'd4);

        // Foreign eaten bits are ignored, including during COOK.
        do_reset();
        bus.wakeup = 3'b010;
        bus.eaten  = 3'b111;
        tick();
        bus.eaten  = 3'b101;
        wait_food("fe_food_rise", 3'b010, 20);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fe_hold%0d", k), {5'd0, bus.food}, 8'h02);
        end
        bus.eaten = 3'b010;
        tick();
        bus.eaten = 3'b000;
        chk("fe_food_drop", {5'd0, bus.food}, 8'h00);
        chk("fe_served", bus.served_cnt, 8'd1);

        // Reset mid-SERVE clears the pointer as well as the counter.
        do_reset();
        bus.wakeup = 3'b001;
        wait_food("rs_food0", 3'b001, 20);
        bus.eaten  = 3'b001;
        bus.wakeup = 3'b100;
        tick();
        bus.eaten = 3'b000;
        wait_food("rs_food2", 3'b100, 20);
        chk("rs_served_pre", bus.served_cnt, 8'd1);
        reset      = 1'b1;
        bus.wakeup = 3'b111;
        tick();
        reset = 1'b0;
        chk("rs_grant", {5'd0, bus.grant}, 8'h00);
        chk("rs_food", {5'd0, bus.food}, 8'h00);
        chk("rs_busy", {7'd0, bus.busy}, 8'h00);
        chk("rs_served", bus.served_cnt, 8'd0);
        tick();
        chk("rs_regrant_kid0", {5'd0, bus.grant}, 8'h01);

        // 256 back-to-back meals: one completes every 6 cycles.
        do_reset();
        bus.wakeup = 3'b001;
        bus.eaten  = 3'b001;
        repeat (6) tick();
        chk("wrap_cnt_c6", bus.served_cnt, 8'd1);
        repeat (1529) tick();
        chk("wrap_cnt_255", bus.served_cnt, 8'd255);
        tick();
        chk("wrap_cnt_0", bus.served_cnt, 8'd0);
        chk("wrap_busy", {7'd0, bus.busy}, 8'h00);
        bus.wakeup = '0;
        bus.eaten  = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/meal_arbiter.md
MEAL_ARBITER -- requirements
Module: meal_arbiter

Interface
REQ-001 The block SHALL have parameter N_KIDS, default 3, giving the number of requesting kids (2..8).
REQ-002 The block SHALL have parameter COOK_CYCLES, default 4, giving the cook duration in clk cycles (1..255).
REQ-003 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port wakeup, input, N_KIDS bits: bit i high means kid i requests a meal (level).
REQ-006 Port eaten, input, N_KIDS bits: bit i high means kid i has taken the food (acknowledge).
REQ-007 Port grant, output, N_KIDS bits: one-hot, identifies the kid currently being cooked for or served.
REQ-008 Port food, output, N_KIDS bits: one-hot, food available to the indicated kid.
REQ-009 Port busy, output, 1 bit: high whenever state is not SLEEP.
REQ-010 Port served_cnt, output, 8 bits: completed-meal counter.

Function
REQ-011 The block SHALL be a Moore FSM with states SLEEP, COOK and SERVE, plus a winner register, a round-robin pointer ptr and a cook counter cnt.
REQ-012 All outputs SHALL decode from registers only, with no combinational path from wakeup or eaten.
- grant = onehot(winner) in COOK or SERVE, else 0.
- food = onehot(winner) in SERVE, else 0.
REQ-013 In SLEEP with wakeup != 0, the block SHALL latch as winner the first set bit of wakeup searching upward from ptr with wrap, clear cnt, and enter COOK on the next edge.
REQ-014 In SLEEP with wakeup == 0, the block SHALL stay in SLEEP.
REQ-015 In COOK with wakeup[winner]=1, cnt SHALL increment each cycle, and when cnt == COOK_CYCLES-1 the next state SHALL be SERVE. Food therefore rises exactly COOK_CYCLES cycles after grant rises.
REQ-016 In COOK, if wakeup[winner]=0 in any cycle, the next state SHALL be SLEEP (abort). On abort, ptr becomes (winner+1) mod N_KIDS and served_cnt is unchanged.
REQ-017 In SERVE, the block SHALL hold food until eaten[winner]=1. Then the next state is SLEEP, ptr becomes (winner+1) mod N_KIDS, and served_cnt increments by 1, wrapping 255 -> 0.
REQ-018 The block SHALL ignore wakeup changes in SERVE; an abort applies only in COOK.
REQ-019 The block SHALL ignore eaten bits other than eaten[winner], and SHALL ignore all eaten bits outside SERVE.
REQ-020 If eaten[winner] and wakeup[winner] are both high in the last SERVE cycle, the meal SHALL complete. The kid is re-granted no earlier than one SLEEP cycle later, and only if no other kid is requesting.
REQ-021 A requesting kid SHALL be granted within N_KIDS arbitration rounds (no starvation).

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL set state=SLEEP, winner=0, ptr=0, cnt=0 and served_cnt=0, so that the next cycle has grant=0, food=0 and busy=0. Reset SHALL take priority in any state, including mid-COOK and mid-SERVE.

Structure
REQ-023 A shared package meal_pkg SHALL hold the state encodings (SLEEP=2'd0, COOK=2'd1, SERVE=2'd2) and the default values of N_KIDS and COOK_CYCLES.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_picker with inputs req[N_KIDS] and ptr and outputs found and idx.
REQ-025 An unused state encoding (2'd3) SHALL return to SLEEP on the next edge.

Verification (N_KIDS=3, COOK_CYCLES=4, cycle 0 = first cycle after reset released)
REQ-026 Single meal.
- Stimulus: wakeup=001 from cycle 0; eaten[0]=1 in cycle 6.
- Response: grant=001 from cycle 1; food=001 in cycles 5-6; food=0 and served_cnt=1 in cycle 7; grant=001 again from cycle 8.
REQ-027 Round robin.
- Stimulus: wakeup=111 held; each eaten pulsed 1 cycle after its food rises.
- Response: grant sequence 001, 010, 100, 001; served_cnt=4 after the fourth meal.
REQ-028 Abort.
- Stimulus: wakeup=001 at cycle 0; wakeup[0]=0 in cycle 3.
- Response: grant=000 and busy=0 in cycle 4; food never asserted; served_cnt=0.
REQ-029 Ignore foreign eaten.
- Stimulus: in SERVE for kid 1, eaten=101 for 3 cycles, then eaten=010.
- Response: food=010 holds throughout the eaten=101 cycles and drops 1 cycle after eaten=010.
REQ-030 Reset mid-SERVE.
- Stimulus: reset=1 for 1 cycle while food=100.
- Response: next cycle grant=0, food=0, busy=0, served_cnt=0; the next grant starts its search from kid 0.
REQ-031 Counter wrap.
- Stimulus: 256 completed meals.
- Response: served_cnt reads 0.
